// File: rtl/pcie_cfg_mgmt_responder.sv
// pcie_cfg_mgmt_responder
//
// Responder end of the PCIe hard-IP cfg_mgmt port. It accepts dword read and
// write requests from a cfg_mgmt initiator and answers them from a local
// config register file that holds REG_COUNT dwords for each function. Every
// access ends with a one-cycle done strobe LATENCY cycles after the request
// is accepted.
//
// Ports
//   clk                       in   clock, rising edge
//   rst_n                     in   asynchronous active-low reset
//   cfg_mgmt_addr             in   [9:0]  dword address
//   cfg_mgmt_function_number  in   [7:0]  target function
//   cfg_mgmt_write            in   write request, held until done
//   cfg_mgmt_write_data       in   [31:0] write data
//   cfg_mgmt_byte_enable      in   [3:0]  byte-lane enables for write data
//   cfg_mgmt_read             in   read request, held until done
//   cfg_mgmt_read_data        out  [31:0] read result, valid with done
//   cfg_mgmt_read_write_done  out  one-cycle completion strobe
//   protocol_err              out  sticky protocol-violation flag
module pcie_cfg_mgmt_responder #(
    parameter int          FUNC_COUNT = 1,
    parameter int          REG_COUNT  = 16,
    parameter int          LATENCY    = 4,
    parameter logic [15:0] VENDOR_ID  = 16'h1234,
    parameter logic [15:0] DEVICE_ID  = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  cfg_mgmt_addr,
    input  logic [7:0]  cfg_mgmt_function_number,
    input  logic        cfg_mgmt_write,
    input  logic [31:0] cfg_mgmt_write_data,
    input  logic [3:0]  cfg_mgmt_byte_enable,
    input  logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_read_data,
    output logic        cfg_mgmt_read_write_done,
    output logic        protocol_err
);

    localparam int DEPTH = FUNC_COUNT * REG_COUNT;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ID_WORD = {DEVICE_ID, VENDOR_ID};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        RELEASE
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg;
    logic [9:0]  addr_reg;
    logic [7:0]  func_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        read_reg;
    logic        write_reg;
    logic [31:0] read_data_reg;
    logic        protocol_err_reg;

    logic        request;
    logic        accept;
    logic        abort;
    logic        complete;

    // Operand selection. With LATENCY=1 the access completes on the same edge
    // that accepts it, so while IDLE the live inputs stand in for the latched
    // copies. In every later state only the latched copies are used, which is
    // what makes mid-access input changes harmless.
    logic        op_live;
    logic [9:0]  op_addr;
    logic [7:0]  op_func;
    logic [31:0] op_wdata;
    logic [3:0]  op_be;
    logic        op_read;
    logic        op_write;
    logic        op_in_range;
    logic [IDX_W-1:0] op_idx;
    logic        wr_en;
    logic [31:0] rd_word;
    logic [31:0] rd_result;

    assign request = cfg_mgmt_read | cfg_mgmt_write;

    assign op_live  = (state_reg == IDLE);
    assign op_addr  = op_live ? cfg_mgmt_addr            : addr_reg;
    assign op_func  = op_live ? cfg_mgmt_function_number : func_reg;
    assign op_wdata = op_live ? cfg_mgmt_write_data      : wdata_reg;
    assign op_be    = op_live ? cfg_mgmt_byte_enable     : be_reg;
    assign op_read  = op_live ? cfg_mgmt_read            : read_reg;
    assign op_write = op_live ? cfg_mgmt_write           : write_reg;

    assign op_in_range = (32'(op_addr) < 32'(REG_COUNT)) && (32'(op_func) < 32'(FUNC_COUNT));

    always_comb begin
        op_idx = '0;
        if (op_in_range) begin
            op_idx = IDX_W'(op_func) * IDX_W'(REG_COUNT) + IDX_W'(op_addr);
        end
    end

    // Dword 0 of every function is the ID constant, so it is never stored.
    assign wr_en = complete && op_write && op_in_range && (op_addr != 10'd0);

    // The register file is split into four byte-lane arrays so that byte
    // enables map onto independent lane writes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        lane_mem[i] <= 8'd0;
                    end
                end else if (wr_en && op_be[gi]) begin
                    lane_mem[op_idx] <= op_wdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[op_idx];
        end
    endgenerate

    // Read result. A read that collides with a write executes as a write and
    // returns 0.
    always_comb begin
        rd_result = 32'd0;
        if (!op_write && op_in_range) begin
            rd_result = (op_addr == 10'd0) ? ID_WORD : rd_word;
        end
    end

    // Next-state logic. count_reg holds the number of BUSY cycles still to
    // go, so leaving BUSY when it reads 1 puts DONE exactly LATENCY cycles
    // after acceptance.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        abort      = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        complete   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!request) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (count_reg == 8'd1) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                // A request still held from the finished access must drop
                // before the next one is accepted.
                if (!request) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            count_reg        <= 8'd0;
            addr_reg         <= 10'd0;
            func_reg         <= 8'd0;
            wdata_reg        <= 32'd0;
            be_reg           <= 4'd0;
            read_reg         <= 1'b0;
            write_reg        <= 1'b0;
            read_data_reg    <= 32'd0;
            protocol_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= cfg_mgmt_addr;
                func_reg  <= cfg_mgmt_function_number;
                wdata_reg <= cfg_mgmt_write_data;
                be_reg    <= cfg_mgmt_byte_enable;
                read_reg  <= cfg_mgmt_read;
                write_reg <= cfg_mgmt_write;
                count_reg <= 8'(LATENCY - 1);
                if (cfg_mgmt_read && cfg_mgmt_write) begin
                    protocol_err_reg <= 1'b1;
                end
            end else if (state_reg == BUSY) begin
                count_reg <= count_reg - 8'd1;
            end
            if (abort) begin
                protocol_err_reg <= 1'b1;
            end
            // read_data only changes when a read completes; writes leave it.
            if (complete && op_read) begin
                read_data_reg <= rd_result;
            end
        end
    end

    assign cfg_mgmt_read_data       = read_data_reg;
    assign cfg_mgmt_read_write_done = (state_reg == DONE);
    assign protocol_err             = protocol_err_reg;

endmodule

// File: tb/tb_pcie_cfg_mgmt_responder.sv
// Testbench for pcie_cfg_mgmt_responder: directed cases plus a randomized
// access stream checked against a behavioural model of the config space.
module tb_pcie_cfg_mgmt_responder;

    localparam int LAT  = 4;
    localparam int NREG = 16;
    localparam int NFN  = 1;
    localparam logic [31:0] ID_WORD = 32'h0001_1234;

    logic        clk;
    logic        rst_n;
    logic [9:0]  addr;
    logic [7:0]  func;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic [31:0] rdata;
    logic        done;
    logic        perr;

    logic        rd_l1, done_l1, perr_l1;
    logic [31:0] rdata_l1;
    logic        rd_l255, done_l255, perr_l255;
    logic [31:0] rdata_l255;

    int checks;
    int errors;

    logic [31:0] model_mem [NREG];
    logic [31:0] last_read;

    pcie_cfg_mgmt_responder #(.FUNC_COUNT(NFN), .REG_COUNT(NREG), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_mgmt_addr(addr), .cfg_mgmt_function_number(func),
        .cfg_mgmt_write(wr), .cfg_mgmt_write_data(wdata),
        .cfg_mgmt_byte_enable(be), .cfg_mgmt_read(rd),
        .cfg_mgmt_read_data(rdata), .cfg_mgmt_read_write_done(done),
        .protocol_err(perr)
    );

    pcie_cfg_mgmt_responder #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .cfg_mgmt_addr(10'd0), .cfg_mgmt_function_number(8'd0),
        .cfg_mgmt_write(1'b0), .cfg_mgmt_write_data(32'd0),
        .cfg_mgmt_byte_enable(4'd0), .cfg_mgmt_read(rd_l1),
        .cfg_mgmt_read_data(rdata_l1), .cfg_mgmt_read_write_done(done_l1),
        .protocol_err(perr_l1)
    );

    pcie_cfg_mgmt_responder #(.LATENCY(255)) dut_l255 (
        .clk(clk), .rst_n(rst_n),
        .cfg_mgmt_addr(10'd0), .cfg_mgmt_function_number(8'd0),
        .cfg_mgmt_write(1'b0), .cfg_mgmt_write_data(32'd0),
        .cfg_mgmt_byte_enable(4'd0), .cfg_mgmt_read(rd_l255),
        .cfg_mgmt_read_data(rdata_l255), .cfg_mgmt_read_write_done(done_l255),
        .protocol_err(perr_l255)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Config-space model: a dword array, ID at dword 0, zeros outside.
    function automatic logic [31:0] model_read(input logic [9:0] a, input logic [7:0] f);
        if (int'(f) >= NFN || int'(a) >= NREG) return 32'd0;
        if (a == 10'd0) return ID_WORD;
        return model_mem[int'(a)];
    endfunction

    function automatic void model_write(input logic [9:0] a, input logic [7:0] f,
                                        input logic [31:0] d, input logic [3:0] b);
        if (int'(f) >= NFN || int'(a) >= NREG || a == 10'd0) return;
        for (int l = 0; l < 4; l++) begin
            if (b[l]) model_mem[int'(a)][8*l +: 8] = d[8*l +: 8];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) model_mem[i] = 32'd0;
        last_read = 32'd0;
    endfunction

    // One complete access on the main instance: measures latency, scrambles
    // the request fields while busy, checks data and the single done pulse.
    task automatic access(input bit do_rd, input bit do_wr, input logic [9:0] a,
                          input logic [7:0] f, input logic [31:0] d, input logic [3:0] b);
        int lat;
        lat = 0;
        addr = a; func = f; wdata = d; be = b; rd = do_rd; wr = do_wr;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                addr  = 10'($urandom);
                wdata = $urandom;
                be    = 4'($urandom);
            end
        end
        rd = 1'b0; wr = 1'b0;
        if (do_wr) model_write(a, f, d, b);
        if (do_rd) last_read = do_wr ? 32'd0 : model_read(a, f);
        check("latency", lat, LAT);
        check("read_data", rdata, last_read);
        $display("access rd=%0b wr=%0b f=%0d a=%0d d=%h be=%b lat=%0d rdata=%h",
                 do_rd, do_wr, f, a, d, b, lat, rdata);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int pulses;
        logic [9:0]  ra;
        logic [7:0]  rf;
        logic [31:0] rdv;
        logic [3:0]  rbe;
        checks = 0; errors = 0;
        rst_n = 1'b0; addr = '0; func = '0; wr = 1'b0; wdata = '0; be = '0; rd = 1'b0;
        rd_l1 = 1'b0; rd_l255 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", done, 1'b0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_perr", perr, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ID read
        access(1, 0, 10'd0, 8'd0, 32'd0, 4'h0);
        check("id_read", rdata, 32'h0001_1234);
        check("id_perr", perr, 1'b0);

        // byte-enabled write then readback
        access(0, 1, 10'd3, 8'd0, 32'hDEADBEEF, 4'b0101);
        access(1, 0, 10'd3, 8'd0, 32'd0, 4'h0);
        check("be_write", rdata, 32'h00AD00EF);

        // out of range and read-only dword 0
        access(1, 0, 10'd20, 8'd0, 32'd0, 4'h0);
        access(1, 0, 10'd1, 8'd1, 32'd0, 4'h0);
        access(0, 1, 10'd0, 8'd0, 32'hFFFFFFFF, 4'hF);
        access(1, 0, 10'd0, 8'd0, 32'd0, 4'h0);
        check("ro_dword0", rdata, 32'h0001_1234);

        // held read: one done pulse only, then re-accept after one low cycle
        rd = 1'b1; addr = 10'd3; func = 8'd0;
        pulses = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                break;
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("held_pulses", pulses, 1);
        rd = 1'b0;
        @(posedge clk); #1;
        access(1, 0, 10'd3, 8'd0, 32'd0, 4'h0);

        // randomized stream
        for (int n = 0; n < 40; n++) begin
            ra  = 10'($urandom_range(0, 19));
            rf  = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
            rdv = $urandom;
            rbe = 4'($urandom);
            if ($urandom_range(0, 1) == 0) access(1, 0, ra, rf, 32'd0, 4'h0);
            else                           access(0, 1, ra, rf, rdv, rbe);
        end
        check("random_perr", perr, 1'b0);

        // latency sweep on the LATENCY=1 and LATENCY=255 instances
        rd_l1 = 1'b1; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done_l1) begin lat = k; break; end
        end
        rd_l1 = 1'b0;
        check("lat1", lat, 1);
        check("lat1_data", rdata_l1, ID_WORD);
        $display("access lat1 lat=%0d rdata=%h", lat, rdata_l1);
        rd_l255 = 1'b1; lat = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (done_l255) begin lat = k; break; end
        end
        rd_l255 = 1'b0;
        check("lat255", lat, 255);
        check("lat255_data", rdata_l255, ID_WORD);
        $display("access lat255 lat=%0d rdata=%h", lat, rdata_l255);
        repeat (2) @(posedge clk);
        #1;

        // abort: write dropped at T+2
        access(0, 1, 10'd7, 8'd0, 32'h1111_2222, 4'hF);
        addr = 10'd7; func = 8'd0; wdata = 32'hCAFE_F00D; be = 4'hF; wr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_perr", perr, 1'b1);
        $display("access abort write a=7");
        access(1, 0, 10'd7, 8'd0, 32'd0, 4'h0);
        check("abort_unchanged", rdata, 32'h1111_2222);

        // simultaneous read and write
        access(1, 1, 10'd9, 8'd0, 32'h5A5A_0F0F, 4'hF);
        check("both_rdata", rdata, 32'd0);
        access(1, 0, 10'd9, 8'd0, 32'd0, 4'h0);
        check("both_perr", perr, 1'b1);

        // reset during a pending write
        access(0, 1, 10'd5, 8'd0, 32'hA5A5_A5A5, 4'hF);
        addr = 10'd5; func = 8'd0; wdata = 32'h1234_5678; be = 4'hF; wr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        wr = 1'b0;
        model_reset();
        check("rst_rdata", rdata, 32'd0);
        check("rst_perr", perr, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("rst_no_done", pulses, 0);
        $display("access reset during write a=5");
        access(1, 0, 10'd5, 8'd0, 32'd0, 4'h0);
        check("rst_addr5", rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
